mux_n_reg: RTL and testbench
============================

MUX_N_REG -- requirements
Module: mux_n_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width of each input channel and of the output.
REQ-002 SHALL have parameter INPUTS, default 3, the number of input channels; legal range is 2..16.
REQ-003 SHALL have parameter SEL_W, default 2, the select width; it SHALL be at least ceil(log2(INPUTS)).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_data  in  INPUTS*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 sel  in  SEL_W  channel index, sampled with in_valid.
REQ-008 in_valid  in  1  upstream holds sel and in_data valid.
REQ-009 in_ready  out  1  block accepts the beat this cycle.
REQ-010 out_data  out  WIDTH  selected, registered data.
REQ-011 out_valid  out  1  out_data valid.
REQ-012 out_ready  in  1  downstream accepts out_data.
REQ-013 sel_err  out  1  sticky flag: an out-of-range sel was accepted.
REQ-014 err_clr  in  1  clears sel_err.

Function
REQ-015 An input transfer SHALL occur in a cycle where in_valid and in_ready are both 1; an output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-016 On an input transfer with sel < INPUTS, the channel-sel slice of in_data SHALL be captured.
REQ-017 On an input transfer with sel >= INPUTS, all-zero data SHALL be captured; the beat is still transferred and sel_err SHALL be set. The block SHALL never drive a high-impedance value.
REQ-018 Latency: captured data SHALL appear on out_data with out_valid=1 in the cycle after the input transfer.
REQ-019 Ordering: beats SHALL leave in acceptance order, with no loss and no duplication.
REQ-020 While out_valid=1 and out_ready=0, out_data SHALL stay stable.
REQ-021 An input transfer and an output transfer in the same cycle SHALL both complete, and throughput SHALL be one beat per cycle.
REQ-022 If err_clr and a new error occur in the same cycle, sel_err SHALL be 1 afterwards (set wins).
REQ-023 in_data and sel SHALL be ignored when in_valid=0.

Reset
REQ-024 While rst=1 at a clock edge, out_valid, sel_err, out_data and all internal storage SHALL be 0 after that edge.
REQ-025 Reset asserted mid-transfer SHALL discard all held beats; in_ready SHALL be 0 during reset cycles.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro MUX_N_REG_SKID_EN SHALL control the buffering mode.
REQ-028 With MUX_N_REG_SKID_EN defined: a 2-entry skid buffer SHALL be used; in_ready SHALL be a registered signal equal to "fewer than 2 entries held"; there SHALL be no combinational path from out_ready to in_ready.
REQ-029 Without MUX_N_REG_SKID_EN: a single output register SHALL be used; in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-030 Function, latency and reset behaviour (REQ-015..026) SHALL be identical in both modes, except for how in_ready is timed.

Verification
REQ-031 Routing (INPUTS=3, WIDTH=32), out_ready=1: send sel=0,1,2 with channels 0x11111111/0x22222222/0x33333333 -> out_data 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, each one cycle after acceptance.
REQ-032 Out of range: sel=3 with INPUTS=3 -> out_data=0, out_valid=1, sel_err=1 and held; err_clr pulse -> sel_err=0; err_clr together with a new sel=3 -> sel_err stays 1.
REQ-033 Backpressure: out_ready=0 for 5 cycles while streaming -> out_data stable.
  - Skid mode: in_ready drops after exactly 2 beats are held.
  - Non-skid mode: in_ready drops after 1 beat is held.
  - After release, all beats SHALL emerge in order with no gaps.
REQ-034 Reset mid-stream: assert rst with 2 beats held -> out_valid=0 and sel_err=0 next cycle; the held beats never appear; in_ready=1 after rst deasserts.
REQ-035 Random stress, 10k cycles: random in_valid, out_ready and sel; both macro settings -> output sequence matches the scoreboard and sel_err matches the reference flag.

Source files
------------

// File: rtl/mux_n_reg.sv
// Registered N-way channel selector with valid/ready handshakes and a sticky
// out-of-range select flag. Define MUX_N_REG_SKID_EN for a 2-entry skid buffer.
module mux_n_reg #(
    parameter int WIDTH  = 32,
    parameter int INPUTS = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    input  logic                    err_clr
);

    logic [WIDTH-1:0] pick;
    logic             pick_err;
    logic             push;
    logic             pop;
    logic             sel_err_q;
    logic             sel_err_d;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        pick     = '0;
        pick_err = 1'b1;
        for (int k = 0; k < INPUTS; k++) begin
            if (sel == SEL_W'(k)) begin
                pick     = in_data[k*WIDTH +: WIDTH];
                pick_err = 1'b0;
            end
        end
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // A new error in the same cycle as err_clr keeps the flag set.
    assign sel_err_d = (sel_err_q && !err_clr) || (push && pick_err);
    assign sel_err   = sel_err_q;

`ifdef MUX_N_REG_SKID_EN
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             full_q;

    // full_q is a flop, so out_ready never reaches in_ready combinationally.
    assign in_ready  = !rst && !full_q;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case ({push, pop})
            2'b10: begin
                count_d = count_q + 2'd1;
                if (count_q == 2'd0) head_d = pick;
                else                 skid_d = pick;
            end
            2'b01: begin
                count_d = count_q - 2'd1;
                head_d  = skid_q;
            end
            2'b11: head_d = pick;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; data storage is reset too so nothing stale survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= 2'd0;
            head_q    <= '0;
            skid_q    <= '0;
            full_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
            full_q    <= (count_d == 2'd2);
            sel_err_q <= sel_err_d;
        end
    end
`else
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;

    assign in_ready  = !rst && (!valid_q || out_ready);
    assign out_valid = valid_q;
    assign out_data  = data_q;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (push) begin
            data_d  = pick;
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; data storage is reset too so nothing stale survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            sel_err_q <= sel_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux_n_reg.sv
// Randomised self-checking bench for mux_n_reg against a queue-based reference model.
// Honours MUX_N_REG_SKID_EN for the expected in_ready timing.
module tb_mux_n_reg;

    localparam int WIDTH  = 32;
    localparam int INPUTS = 3;
    localparam int SEL_W  = 2;
`ifdef MUX_N_REG_SKID_EN
    localparam bit SKID = 1'b1;
    localparam int CAP  = 2;
`else
    localparam bit SKID = 1'b0;
    localparam int CAP  = 1;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [INPUTS*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    sel_err;
    logic                    err_clr;

    logic [WIDTH-1:0] exp_q[$];
    bit               exp_err;
    int               n_push;
    int               total;
    int               bad;

    mux_n_reg #(.WIDTH(WIDTH), .INPUTS(INPUTS), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive, check against the model mid-cycle, then advance the model at the edge.
    task automatic cycle(input logic v, input int s, input logic [95:0] d,
                         input logic ordy, input logic clr, input logic r);
        logic            exp_ready;
        logic            do_push;
        logic            do_pop;
        logic [31:0]     beat;
        in_valid  = v;
        sel       = 2'(s);
        in_data   = d;
        out_ready = ordy;
        err_clr   = clr;
        rst       = r;
        @(negedge clk);
        if (r)         exp_ready = 1'b0;
        else if (SKID) exp_ready = (exp_q.size() < CAP);
        else           exp_ready = (exp_q.size() == 0) || ordy;
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        check("sel_err", 32'(sel_err), 32'(exp_err));
        if (exp_q.size() > 0) check("out_data", out_data, exp_q[0]);
        do_push = v && exp_ready;
        do_pop  = (exp_q.size() > 0) && ordy;
        beat    = (s < INPUTS) ? d[s*WIDTH +: WIDTH] : 32'h0;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(beat);
                n_push++;
            end
            exp_err = (exp_err && !clr) || (do_push && s >= INPUTS);
        end
        #1;
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [95:0] chan;
        total   = 0;
        bad     = 0;
        n_push  = 0;
        exp_err = 1'b0;
        chan    = {32'h33333333, 32'h22222222, 32'h11111111};
        rst = 1'b1; in_valid = 1'b0; sel = '0; in_data = '0; out_ready = 1'b0; err_clr = 1'b0;

        // Reset state
        cycle(1'b0, 0, '0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1, chan, 1'b1, 1'b0, 1'b1);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);

        // Routing, one beat per cycle
        cycle(1'b1, 0, chan, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1, chan, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2, chan, 1'b1, 1'b0, 1'b0);
        check("route_last", out_data, 32'h33333333);
        cycle(1'b0, 3, rnd96(), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 0, rnd96(), 1'b1, 1'b0, 1'b0);

        // Out-of-range select and the sticky flag
        cycle(1'b1, 3, chan, 1'b1, 1'b0, 1'b0);
        check("oor_data", out_data, 32'h0);
        check("oor_err", 32'(sel_err), 32'h1);
        cycle(1'b0, 0, chan, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 0, chan, 1'b1, 1'b0, 1'b0);
        check("oor_held", 32'(sel_err), 32'h1);
        cycle(1'b0, 0, chan, 1'b1, 1'b1, 1'b0);
        check("clr_err", 32'(sel_err), 32'h0);
        cycle(1'b1, 1, chan, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 3, chan, 1'b1, 1'b1, 1'b0);
        check("set_wins", 32'(sel_err), 32'h1);
        cycle(1'b0, 0, chan, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 0, chan, 1'b1, 1'b0, 1'b0);

        // Backpressure while streaming, then release
        n_push = 0;
        for (int i = 0; i < 5; i++) cycle(1'b1, i % 3, rnd96(), 1'b0, 1'b0, 1'b0);
        check("bp_held", n_push, CAP);
        for (int i = 0; i < 8; i++) cycle(1'b1, i % 3, rnd96(), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, rnd96(), 1'b1, 1'b0, 1'b0);

        // Reset with beats held
        for (int i = 0; i < 3; i++) cycle(1'b1, 3, rnd96(), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 0, rnd96(), 1'b0, 1'b0, 1'b1);
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_err", 32'(sel_err), 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, rnd96(), 1'b1, 1'b0, 1'b0);

        // Random stress
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), rnd96(),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 499) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
